imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Write-side counterpart of the byte-wide instruction memory: accepts 32-bit instruction
//  words over a valid/ready handshake and emits them as four sequential 8-bit writes,
//  big-endian (bits [31:24] at the base byte address, [7:0] at base+3).
//  Drives the memory's byte write port during program load/self-modify, before fetch begins.
// PARAMETERS
//  MEM_DEPTH  128  memory size in bytes; legal word base addresses are 0..MEM_DEPTH-4
// PORTS
//  CLK       in   1   clock, rising edge
//  Reset     in   1   asynchronous, active-high reset
//  WValid    in   1   WAddr/WData valid
//  WReady    out  1   loader idle, can accept a word
//  WAddr     in   32  byte address of word
//  WData     in   32  instruction word
//  MemWE     out  1   byte write enable to memory
//  MemAddr   out  32  byte address to memory
//  MemWData  out  8   byte write data
//  Done      out  1   one-cycle pulse: request finished (written or rejected)
//  AddrErr   out  1   one-cycle pulse with Done: request rejected
//  MemRData  in   8   byte read data, combinational (READBACK_VERIFY_EN only)
//  VerifyErr out  1   one-cycle pulse with Done: readback mismatch (READBACK_VERIFY_EN only)
// BEHAVIOUR
//  - Reset (any time, async): state IDLE, MemWE=0, MemAddr=0, MemWData=0, Done=0,
//    AddrErr=0, VerifyErr=0. WReady=1 (IDLE) but no handshake while Reset=1.
//  - WReady = (state==IDLE). Handshake = WValid & WReady at a rising edge; WAddr/WData
//    registered then; later input changes ignored. WValid while busy ignored; sender holds.
//  - Address check at handshake: WAddr[1:0]!=0 or WAddr>MEM_DEPTH-4 -> no writes; next
//    cycle Done=1, AddrErr=1; state stays IDLE (WReady stays 1).
//  - States: IDLE -> WR0 -> WR1 -> WR2 -> WR3 -> [VF0..VF3] -> IDLE.
//  - WRk (k=0..3), cycles 1..4 after handshake: MemWE=1, MemAddr=base+k,
//    MemWData=WData[31-8k -: 8]. MemWE/MemAddr/MemWData registered outputs.
//  - Outside write cycles: MemWE=0; MemAddr/MemWData hold last value (MemAddr changes in VFk).
//  - Address arithmetic 32-bit; base+3 cannot wrap (range-checked).
//  - Done=1 (AddrErr=0) in the first IDLE cycle after final state: cycle 5 after handshake
//    without verify. New handshake allowed in that same cycle: one word per 5 cycles.
//  - Reset mid-request: bytes already written stay in memory; no Done; request dropped.
// CONFIGURATION
//  READBACK_VERIFY_EN defined:
//   - MemRData input and VerifyErr output exist; VF0..VF3 follow WR3.
//   - VFk: MemWE=0, MemAddr=base+k, MemRData compared same cycle with expected byte;
//     any mismatch sets an internal flag cleared at each handshake.
//   - Done at cycle 9 after handshake; VerifyErr=flag in the Done cycle, else 0.
//   - AddrErr requests skip verify; VerifyErr=0.
//  READBACK_VERIFY_EN undefined:
//   - no MemRData/VerifyErr ports; no VF states; Done at cycle 5 after handshake.
// TESTING
//  1 WAddr=0x8, WData=0x8C220004 -> MemWE 4 cycles: (8,8C)(9,22)(A,00)(B,04); Done cycle 5.
//  2 WAddr=0x6 (misaligned), WAddr=0x7D (>124) -> no MemWE; Done+AddrErr next cycle each.
//  3 WAddr=0x7C (last legal), WData=0xFFFFFFFF -> writes 0x7C..0x7F=FF, AddrErr=0.
//  4 WValid held high with 3 words -> each accepted only when WReady=1; no byte lost or
//    duplicated; 5-cycle spacing (9 with verify).
//  5 Reset pulse during WR2 -> outputs reset immediately; only 2 bytes written; no Done;
//    next request after Reset completes normally.
//  6 [READBACK_VERIFY_EN] memory model corrupts base+2 -> VerifyErr=1 with Done at cycle 9;
//    clean model -> VerifyErr=0.

Source files
------------

// File: rtl/imem_loader_if.sv
// Request-side interface of the instruction-memory loader: a 32-bit word with its
// byte address goes in over valid/ready, and a completion pulse comes back with status.
// verify_err is present only when READBACK_VERIFY_EN is defined.
interface imem_loader_if;
  logic        wvalid;
  logic        wready;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        done;
  logic        addr_err;
`ifdef READBACK_VERIFY_EN
  logic        verify_err;
`endif

  // Sender side: presents words and holds them until accepted.
  modport master (
    output wvalid, waddr, wdata,
    input  wready, done, addr_err
`ifdef READBACK_VERIFY_EN
    , input verify_err
`endif
  );

  // Loader side.
  modport slave (
    input  wvalid, waddr, wdata,
    output wready, done, addr_err
`ifdef READBACK_VERIFY_EN
    , output verify_err
`endif
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: turns each accepted 32-bit instruction word into four big-endian byte
// writes (bits [31:24] at the base address, [7:0] at base+3) on the memory's byte port.
// Misaligned or out-of-range bases are rejected with a Done+AddrErr pulse.
// Optional feature macro READBACK_VERIFY_EN: after the writes, the four bytes are read
// back through mem_rdata and compared; a mismatch is reported on verify_err with done.
module imem_loader #(
  parameter int MEM_DEPTH = 128
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [7:0]   mem_wdata
`ifdef READBACK_VERIFY_EN
  , input  logic [7:0] mem_rdata
`endif
);

  localparam logic [31:0] LAST_BASE = 32'(MEM_DEPTH - 4);

`ifdef READBACK_VERIFY_EN
  typedef enum logic [3:0] {IDLE, WR0, WR1, WR2, WR3, VF0, VF1, VF2, VF3} state_t;
`else
  typedef enum logic [2:0] {IDLE, WR0, WR1, WR2, WR3} state_t;
`endif

  state_t      state, state_n;
  logic [31:0] base_q, base_n;
  logic [31:0] word_q, word_n;
  logic        we_n;
  logic [31:0] addr_n;
  logic [7:0]  wdata_n;
  logic        done_q, done_n;
  logic        aerr_q, aerr_n;
  logic        bad_addr;
`ifdef READBACK_VERIFY_EN
  logic        flag_q, flag_n;
  logic        verr_q, verr_n;
  logic        rd_bad;
`endif

  // Byte k of a word in big-endian order (k=0 is the most significant byte).
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
    logic [7:0] b;
    unique case (k)
      2'd0: b = w[31:24];
      2'd1: b = w[23:16];
      2'd2: b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  assign bus.wready   = (state == IDLE);
  assign bus.done     = done_q;
  assign bus.addr_err = aerr_q;
`ifdef READBACK_VERIFY_EN
  assign bus.verify_err = verr_q;
`endif

  assign bad_addr = (bus.waddr[1:0] != 2'b00) || (bus.waddr > LAST_BASE);

  // Next-state and next-output logic; memory outputs are computed one cycle ahead
  // so that they leave the loader straight from flops.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_n = state;
    base_n  = base_q;
    word_n  = word_q;
    we_n    = 1'b0;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    done_n  = 1'b0;
    aerr_n  = 1'b0;
`ifdef READBACK_VERIFY_EN
    flag_n  = flag_q;
    verr_n  = 1'b0;
    rd_bad  = (mem_rdata != byte_sel(word_q, mem_addr[1:0]));
`endif
    unique case (state)
      IDLE: begin
        if (bus.wvalid) begin
`ifdef READBACK_VERIFY_EN
          flag_n = 1'b0;
`endif
          if (bad_addr) begin
            done_n = 1'b1;
            aerr_n = 1'b1;
          end else begin
            state_n = WR0;
            base_n  = bus.waddr;
            word_n  = bus.wdata;
            we_n    = 1'b1;
            addr_n  = bus.waddr;
            wdata_n = bus.wdata[31:24];
          end
        end
      end
      WR0: begin
        state_n = WR1;
        we_n    = 1'b1;
        addr_n  = base_q + 32'd1;
        wdata_n = byte_sel(word_q, 2'd1);
      end
      WR1: begin
        state_n = WR2;
        we_n    = 1'b1;
        addr_n  = base_q + 32'd2;
        wdata_n = byte_sel(word_q, 2'd2);
      end
      WR2: begin
        state_n = WR3;
        we_n    = 1'b1;
        addr_n  = base_q + 32'd3;
        wdata_n = byte_sel(word_q, 2'd3);
      end
`ifdef READBACK_VERIFY_EN
      WR3: begin
        state_n = VF0;
        addr_n  = base_q;
      end
      VF0: begin
        state_n = VF1;
        flag_n  = flag_q | rd_bad;
        addr_n  = base_q + 32'd1;
      end
      VF1: begin
        state_n = VF2;
        flag_n  = flag_q | rd_bad;
        addr_n  = base_q + 32'd2;
      end
      VF2: begin
        state_n = VF3;
        flag_n  = flag_q | rd_bad;
        addr_n  = base_q + 32'd3;
      end
      VF3: begin
        state_n = IDLE;
        flag_n  = flag_q | rd_bad;
        done_n  = 1'b1;
        verr_n  = flag_q | rd_bad;
      end
`else
      WR3: begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // State register and registered outputs; reset drops any request in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      base_q    <= '0;
      word_q    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done_q    <= 1'b0;
      aerr_q    <= 1'b0;
`ifdef READBACK_VERIFY_EN
      flag_q    <= 1'b0;
      verr_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state     <= state_n;
      base_q    <= base_n;
      word_q    <= word_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      done_q    <= done_n;
      aerr_q    <= aerr_n;
`ifdef READBACK_VERIFY_EN
      flag_q    <= flag_n;
      verr_q    <= verr_n;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: a byte-array memory model captures the write
// port; expected bytes, addresses and pulse timing are written out by hand.
// Build with READBACK_VERIFY_EN defined to exercise the readback-verify path.
module tb_imem_loader;

`ifdef READBACK_VERIFY_EN
  localparam int SPACING = 9;
`else
  localparam int SPACING = 5;
`endif

  logic        clk;
  logic        rst;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  tbmem [128];
  int          n_wr;
  int          cyc;
  int          n_cmp;
  int          n_err;
`ifdef READBACK_VERIFY_EN
  logic [7:0]  mem_rdata;
  logic        corrupt_en;
  logic [31:0] corrupt_addr;
`endif

  imem_loader_if bus ();

  imem_loader #(.MEM_DEPTH(128)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
`ifdef READBACK_VERIFY_EN
    , .mem_rdata (mem_rdata)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Byte-wide memory model and write counter.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      tbmem[mem_addr[6:0]] <= mem_wdata;
      n_wr <= n_wr + 1;
    end
  end

`ifdef READBACK_VERIFY_EN
  assign mem_rdata = (corrupt_en && mem_addr == corrupt_addr) ?
                     ~tbmem[mem_addr[6:0]] : tbmem[mem_addr[6:0]];
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected byte k of word d, big-endian.
  function automatic logic [7:0] exp_byte(input logic [31:0] d, input int k);
    logic [31:0] s;
    s = d >> (24 - 8 * k);
    return s[7:0];
  endfunction

  // One legal word: handshake, four writes (then four verify reads), Done pulse.
  task automatic run_word(input logic [31:0] a, input logic [31:0] d, input logic exp_verr);
    bus.wvalid = 1'b1;
    bus.waddr  = a;
    bus.wdata  = d;
    check($sformatf("ready@%0h", a), bus.wready, 1'b1);
    tick();
    bus.wvalid = 1'b0;
    bus.waddr  = 32'h5555_5555;
    bus.wdata  = 32'hAAAA_AAAA;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("we%0d@%0h", k, a), mem_we, 1'b1);
      check($sformatf("addr%0d@%0h", k, a), mem_addr, a + 32'(k));
      check($sformatf("data%0d@%0h", k, a), mem_wdata, exp_byte(d, k));
      check($sformatf("busy%0d@%0h", k, a), {bus.wready, bus.done}, 2'b00);
      tick();
    end
`ifdef READBACK_VERIFY_EN
    for (int k = 0; k < 4; k++) begin
      check($sformatf("vf_we%0d@%0h", k, a), mem_we, 1'b0);
      check($sformatf("vf_addr%0d@%0h", k, a), mem_addr, a + 32'(k));
      check($sformatf("vf_busy%0d@%0h", k, a), {bus.wready, bus.done}, 2'b00);
      tick();
    end
    check($sformatf("verr@%0h", a), bus.verify_err, exp_verr);
`else
    check($sformatf("verr_exp@%0h", a), exp_verr, 1'b0);
`endif
    check($sformatf("done@%0h", a), bus.done, 1'b1);
    check($sformatf("aerr@%0h", a), bus.addr_err, 1'b0);
    check($sformatf("idle_we@%0h", a), mem_we, 1'b0);
    check($sformatf("hold_addr@%0h", a), mem_addr, a + 32'd3);
    check($sformatf("idle_ready@%0h", a), bus.wready, 1'b1);
    tick();
    check($sformatf("done_clr@%0h", a), bus.done, 1'b0);
  endtask

  // One rejected word: no writes, Done+AddrErr in the next cycle, still idle.
  task automatic run_bad(input logic [31:0] a);
    int wr0;
    wr0 = n_wr;
    bus.wvalid = 1'b1;
    bus.waddr  = a;
    bus.wdata  = 32'h1234_5678;
    tick();
    bus.wvalid = 1'b0;
    check($sformatf("bad_done@%0h", a), bus.done, 1'b1);
    check($sformatf("bad_aerr@%0h", a), bus.addr_err, 1'b1);
    check($sformatf("bad_we@%0h", a), mem_we, 1'b0);
    check($sformatf("bad_ready@%0h", a), bus.wready, 1'b1);
`ifdef READBACK_VERIFY_EN
    check($sformatf("bad_verr@%0h", a), bus.verify_err, 1'b0);
`endif
    tick();
    check($sformatf("bad_clr@%0h", a), {bus.done, bus.addr_err}, 2'b00);
    check($sformatf("bad_nowr@%0h", a), n_wr, wr0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wa [3];
    logic [31:0] wd [3];
    int          hs [3];
    int          i;
    int          guard;
    int          wr0;
    int          done_seen;

    n_cmp = 0;
    n_err = 0;
    n_wr  = 0;
    cyc   = 0;
    for (int m = 0; m < 128; m++) tbmem[m] = 8'h00;
`ifdef READBACK_VERIFY_EN
    corrupt_en   = 1'b0;
    corrupt_addr = 32'h0;
`endif
    rst        = 1'b1;
    bus.wvalid = 1'b1;
    bus.waddr  = 32'h8;
    bus.wdata  = 32'hFFFF_FFFF;

    // Reset state, with wvalid asserted to show no handshake happens under reset.
    #3;
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 8'h00);
    check("rst_flags", {bus.done, bus.addr_err}, 2'b00);
    check("rst_ready", bus.wready, 1'b1);
    tick();
    tick();
    check("rst_hold_we", mem_we, 1'b0);
    check("rst_nowr", n_wr, 0);
    bus.wvalid = 1'b0;
    rst = 1'b0;
    tick();

    // Test 1: basic word.
    run_word(32'h8, 32'h8C22_0004, 1'b0);
    check("t1_m8", tbmem[8'h08], 8'h8C);
    check("t1_m9", tbmem[8'h09], 8'h22);
    check("t1_mA", tbmem[8'h0A], 8'h00);
    check("t1_mB", tbmem[8'h0B], 8'h04);

    // Test 2: rejected addresses.
    run_bad(32'h6);
    run_bad(32'h7D);
    run_bad(32'h80);
    run_bad(32'hFFFF_FFFC);

    // Test 3: last legal base.
    run_word(32'h7C, 32'hFFFF_FFFF, 1'b0);
    for (int m = 124; m < 128; m++) check($sformatf("t3_m%0h", m), tbmem[m], 8'hFF);

    // Test 4: wvalid held high across three words.
    wa[0] = 32'h10; wd[0] = 32'h1122_3344;
    wa[1] = 32'h14; wd[1] = 32'hA5A5_5A5A;
    wa[2] = 32'h18; wd[2] = 32'hDEAD_BEEF;
    wr0 = n_wr;
    i = 0;
    guard = 0;
    bus.wvalid = 1'b1;
    bus.waddr  = wa[0];
    bus.wdata  = wd[0];
    while (i < 3 && guard < 100) begin
      if (bus.wready) begin
        hs[i] = cyc;
        i++;
        tick();
        if (i < 3) begin
          bus.waddr = wa[i];
          bus.wdata = wd[i];
        end
      end else begin
        tick();
      end
      guard++;
    end
    bus.wvalid = 1'b0;
    check("t4_accepted", i, 3);
    if (i == 3) begin
      check("t4_gap01", hs[1] - hs[0], SPACING);
      check("t4_gap12", hs[2] - hs[1], SPACING);
    end
    for (int k = 0; k < SPACING - 1; k++) tick();
    check("t4_done", bus.done, 1'b1);
    check("t4_nwr", n_wr - wr0, 12);
    for (int w = 0; w < 3; w++)
      for (int k = 0; k < 4; k++)
        check($sformatf("t4_m%0h", wa[w] + 32'(k)), tbmem[wa[w][6:0] + 7'(k)], exp_byte(wd[w], k));
    tick();

    // Test 5: reset pulse while the third byte is on the port.
    wr0 = n_wr;
    bus.wvalid = 1'b1;
    bus.waddr  = 32'h20;
    bus.wdata  = 32'h0102_0304;
    tick();
    bus.wvalid = 1'b0;
    tick();
    tick();
    check("t5_wr2_addr", mem_addr, 32'h22);
    rst = 1'b1;
    #1;
    check("t5_rst_we", mem_we, 1'b0);
    check("t5_rst_addr", mem_addr, 32'h0);
    check("t5_rst_wdata", mem_wdata, 8'h00);
    check("t5_rst_ready", bus.wready, 1'b1);
    tick();
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.done) done_seen++;
      tick();
    end
    check("t5_no_done", done_seen, 0);
    check("t5_nwr", n_wr - wr0, 2);
    check("t5_m20", tbmem[8'h20], 8'h01);
    check("t5_m21", tbmem[8'h21], 8'h02);
    check("t5_m22", tbmem[8'h22], 8'h00);
    run_word(32'h20, 32'h0102_0304, 1'b0);
    check("t5_m23", tbmem[8'h23], 8'h04);

`ifdef READBACK_VERIFY_EN
    // Test 6: corrupted readback, then a clean one.
    corrupt_en   = 1'b1;
    corrupt_addr = 32'h2A;
    run_word(32'h28, 32'hCAFE_F00D, 1'b1);
    corrupt_en = 1'b0;
    run_word(32'h28, 32'hCAFE_F00D, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
